// File: rtl/arc4_if.sv
// Memory and handshake bundle for arc4_encrypt: start/ready, key, and the
// plaintext, ciphertext and S memory ports. master = encryptor side.
interface arc4_if #(
    parameter int KEY_BYTES = 3
);
    logic                   en;
    logic                   rdy;
    logic [8*KEY_BYTES-1:0] key;
    logic [7:0]             pt_addr;
    logic [7:0]             pt_rddata;
    logic [7:0]             ct_addr;
    logic [7:0]             ct_wrdata;
    logic                   ct_wren;
    logic [7:0]             s_addr;
    logic [7:0]             s_rddata;
    logic [7:0]             s_wrdata;
    logic                   s_wren;

    modport master (
        input  en, key, pt_rddata, s_rddata,
        output rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, s_addr, s_wrdata, s_wren
    );

    modport slave (
        output en, key, pt_rddata, s_rddata,
        input  rdy, pt_addr, ct_addr, ct_wrdata, ct_wren, s_addr, s_wrdata, s_wren
    );
endinterface

// File: rtl/arc4_encrypt.sv
// ARC4 stream encryptor: length-prefixed pt memory -> length-prefixed ct memory.
// Define ARC4_CYCLE_COUNT_EN to add the busy_cycles run-length counter output.
//
// Handshake: en is accepted at a rising edge only while rdy=1; key is latched
// then; rdy stays 0 until the run finishes (1795 + 9*L cycles).
module arc4_encrypt #(
    parameter int KEY_BYTES = 3
) (
    input  logic       clk,
    input  logic       rst,
    arc4_if.master     bus,
    output logic [4:0] state_dbg
`ifdef ARC4_CYCLE_COUNT_EN
    ,
    output logic [31:0] busy_cycles
`endif
);
    localparam logic [4:0] S_IDLE = 5'd0,  S_INIT = 5'd1,
                           K_RDI  = 5'd2,  K_WI   = 5'd3,  K_RDJ  = 5'd4,
                           K_WJ   = 5'd5,  K_WRI  = 5'd6,  K_WRJ  = 5'd7,
                           P_LEN  = 5'd8,  P_LW   = 5'd9,  P_LWR  = 5'd10,
                           P_RDI  = 5'd11, P_WI   = 5'd12, P_RDJ  = 5'd13,
                           P_WJ   = 5'd14, P_WRI  = 5'd15, P_WRJ  = 5'd16,
                           P_RDK  = 5'd17, P_WK   = 5'd18, P_WRCT = 5'd19;

    logic [4:0]             state;
    logic [7:0]             i, j, si, sj, len;
    logic [8:0]             k;
    logic [8*KEY_BYTES-1:0] key_reg;
    logic [7:0]             kb, i_inc, j_ksa, j_prga, pad_addr;
    int                     kidx;

    assign state_dbg = state;
    assign bus.rdy   = (state == S_IDLE);

    // Key byte 0 is the most significant byte of the key word.
    always_comb begin
        kb   = 8'h00;
        kidx = int'(i) % KEY_BYTES;
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (kidx == n) kb = key_reg[8*(KEY_BYTES-n)-1 -: 8];
        end
    end

    assign i_inc    = i + 8'd1;
    assign j_ksa    = j + bus.s_rddata + kb;
    assign j_prga   = j + bus.s_rddata;
    assign pad_addr = si + sj;

    // Wait states repeat the read address so the registered memory output holds.
    always_comb begin
        bus.pt_addr   = 8'h00;
        bus.ct_addr   = 8'h00;
        bus.ct_wrdata = 8'h00;
        bus.ct_wren   = 1'b0;
        bus.s_addr    = 8'h00;
        bus.s_wrdata  = 8'h00;
        bus.s_wren    = 1'b0;
        case (state)
            S_INIT: begin
                bus.s_addr = i; bus.s_wrdata = i; bus.s_wren = 1'b1;
            end
            K_RDI, K_WI, P_WI: bus.s_addr = i;
            K_RDJ:             bus.s_addr = j_ksa;
            K_WJ, P_WJ:        bus.s_addr = j;
            K_WRI, P_WRI: begin
                bus.s_addr = i; bus.s_wrdata = bus.s_rddata; bus.s_wren = 1'b1;
            end
            K_WRJ, P_WRJ: begin
                bus.s_addr = j; bus.s_wrdata = si; bus.s_wren = 1'b1;
            end
            P_LWR: begin
                bus.ct_wrdata = bus.pt_rddata; bus.ct_wren = 1'b1;
            end
            P_RDI: bus.s_addr = i_inc;
            P_RDJ: bus.s_addr = j_prga;
            P_RDK, P_WK: begin
                bus.s_addr = pad_addr; bus.pt_addr = k[7:0];
            end
            P_WRCT: begin
                bus.ct_addr   = k[7:0];
                bus.ct_wrdata = bus.pt_rddata ^ bus.s_rddata;
                bus.ct_wren   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            i       <= 8'h00;
            j       <= 8'h00;
            si      <= 8'h00;
            sj      <= 8'h00;
            len     <= 8'h00;
            k       <= 9'h000;
            key_reg <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.en) begin
                    key_reg <= bus.key;
                    i       <= 8'h00;
                    j       <= 8'h00;
                    si      <= 8'h00;
                    sj      <= 8'h00;
                    len     <= 8'h00;
                    k       <= 9'h000;
                    state   <= S_INIT;
                end
                S_INIT: begin
                    i <= i_inc;
                    if (i == 8'hFF) state <= K_RDI;
                end
                K_RDI: state <= K_WI;
                K_WI:  state <= K_RDJ;
                K_RDJ: begin
                    si    <= bus.s_rddata;
                    j     <= j_ksa;
                    state <= K_WJ;
                end
                K_WJ:  state <= K_WRI;
                K_WRI: state <= K_WRJ;
                K_WRJ: begin
                    i     <= i_inc;
                    state <= (i == 8'hFF) ? P_LEN : K_RDI;
                end
                P_LEN: state <= P_LW;
                P_LW:  state <= P_LWR;
                P_LWR: begin
                    len   <= bus.pt_rddata;
                    i     <= 8'h00;
                    j     <= 8'h00;
                    k     <= 9'd1;
                    state <= (bus.pt_rddata == 8'h00) ? S_IDLE : P_RDI;
                end
                P_RDI: begin
                    i     <= i_inc;
                    state <= P_WI;
                end
                P_WI:  state <= P_RDJ;
                P_RDJ: begin
                    si    <= bus.s_rddata;
                    j     <= j_prga;
                    state <= P_WJ;
                end
                P_WJ:  state <= P_WRI;
                P_WRI: begin
                    sj    <= bus.s_rddata;
                    state <= P_WRJ;
                end
                P_WRJ: state <= P_RDK;
                P_RDK: state <= P_WK;
                P_WK:  state <= P_WRCT;
                P_WRCT: begin
                    k     <= k + 9'd1;
                    state <= (k >= {1'b0, len}) ? S_IDLE : P_RDI;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ARC4_CYCLE_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              busy_cycles <= 32'h0;
        else if (state == S_IDLE && bus.en)   busy_cycles <= 32'h0;
        else if (state != S_IDLE)             busy_cycles <= busy_cycles + 32'h1;
    end
`endif
endmodule

// File: doc/arc4_encrypt.md
Name: arc4_encrypt

Overview:
- ARC4 stream encryptor; the writer-side counterpart of the cracking datapath, which only reads ciphertext memory.
- Reads a length-prefixed plaintext from pt memory and writes the length-prefixed ciphertext into ct memory.
- Uses the 24-bit key and an external 256-byte S memory.
- Bench and loader flows use it to generate ct_mem images for the crack circuits; it also serves as a standalone decrypt, since ARC4 is symmetric.

Parameters:
- KEY_BYTES, 3, key length in bytes. Key byte n = key[8*(KEY_BYTES-n)-1 -: 8], so byte 0 is the MSB byte.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- en  input  1  start request; honoured only when rdy=1
- rdy  output  1  idle/ready
- key  input  8*KEY_BYTES  cipher key; sampled on accepted en
- pt_addr  output  8  plaintext memory read address
- pt_rddata  input  8  plaintext read data
- ct_addr  output  8  ciphertext memory address
- ct_wrdata  output  8  ciphertext write data
- ct_wren  output  1  ciphertext write enable
- s_addr  output  8  S memory address
- s_rddata  input  8  S read data
- s_wrdata  output  8  S write data
- s_wren  output  1  S write enable

Behaviour:
- Reset (async, any state): state=IDLE, rdy=1, all addresses/data=0, ct_wren=0, s_wren=0, internal i/j/k/len/key register=0. Reset mid-operation abandons the run; partial ct contents are not restored.
- Memories are synchronous-read. An address presented in cycle t is sampled in cycle t+2 (one WAIT state after every read issue).
- Handshake:
  - en && rdy at a rising edge accepts the request and latches key; rdy=0 from the next cycle.
  - en while rdy=0 is ignored. en held high after completion starts a new run.
  - rdy returns to 1 when the run completes; it stays 0 for exactly 1795 + 9*L cycles, where L = pt[0].
- States, one cycle each unless noted:
  - IDLE.
  - INIT: 256 cycles; s[i]=i, i=0..255.
  - KSA loop, i=0..255, j starts at 0:
    - K_RDI: read s[i].
    - K_WI: wait.
    - K_RDJ: j = j + s[i] + keybyte[i mod KEY_BYTES], mod 256; read s[j].
    - K_WJ: wait.
    - K_WRI: s[i]=s[j].
    - K_WRJ: s[j]=old s[i].
  - P_LEN: read pt[0]. P_LW: wait. P_LWR: ct[0]=L; i=j=0, k=1.
  - Per byte while k<=L:
    - P_RDI: i=i+1; read s[i].
    - P_WI: wait.
    - P_RDJ: j=j+s[i]; read s[j].
    - P_WJ: wait.
    - P_WRI: s[i]=s[j].
    - P_WRJ: s[j]=old s[i].
    - P_RDK: read s[(s_i+s_j) mod 256] on the S port and pt[k] on the pt port.
    - P_WK: wait.
    - P_WRCT: ct[k] = pt[k] XOR pad; k=k+1.
  - Then IDLE.
- Arithmetic: all index arithmetic is 8-bit wraparound. k is 9 bits so L=255 terminates.
- Swap with i==j: both writes hit the same address with the same value; S stays unchanged.
- L=0: ct[0]=0 and no further ct writes; KSA still runs.
- ct_wren is high only in P_LWR and P_WRCT; s_wren is high only in INIT, K_WRI/J and P_WRI/J.

Optional Feature:
- ARC4_CYCLE_COUNT_EN defined: adds output busy_cycles [31:0].
  - Cleared on accepted en; increments every cycle rdy=0; holds its value while idle; reset to 0.
  - Must equal 1795 + 9*L after a run.
- Undefined: port absent, no counter logic.

Test Plan:
- key=24'h4B6579 ("Key"), pt = {9, "Plaintext"} -> ct[0]=09, ct[1..9]=BB F3 16 E8 D9 40 AF 0A D3; rdy low 1876 cycles.
- Round trip: encrypt a random 32-byte pt with key=24'h1A2B3C, copy ct into pt, re-run -> ct[1..32] equals the original pt bytes.
- L=0, key=24'h000000 -> exactly one ct write (addr 0, data 00); rdy low 1795 cycles.
- L=255 with all-zero pt -> 256 ct writes, addrs 0..255; ct[1..255] equals the reference-model keystream; k does not wrap.
- Pulse en repeatedly while busy -> no restart; key change mid-run has no effect on output.
- Assert rst at cycle 1000 of a run -> rdy=1 and all write enables 0 immediately; a following en produces a correct full run.
